// File: rtl/aurora_link_supervisor_if.sv
// Purpose: status/control bundle between the Aurora link supervisor and its environment.
// Latency: wires only, no storage.
// Backpressure: none; every signal is a level.
// Ports (supervisor view, modport master):
//   hmc7044_config_ok_i  clock chip configured (async)
//   lane_en_i            per-lane enable (clk_100m domain, quasi-static)
//   channel_up_i         per-lane Aurora channel_up (async)
//   link_rst_req_o       per-lane reset request, active high
//   link_ok_o            per-lane link up and stable
//   link_fail_o          per-lane retries exhausted
//   retry_cnt_o          per-lane failed-attempt count, lane i at [4i+3:4i]
interface aurora_link_supervisor_if #(
    parameter int LANES = 4
);
    logic                 hmc7044_config_ok_i;
    logic [LANES-1:0]     lane_en_i;
    logic [LANES-1:0]     channel_up_i;
    logic [LANES-1:0]     link_rst_req_o;
    logic [LANES-1:0]     link_ok_o;
    logic [LANES-1:0]     link_fail_o;
    logic [4*LANES-1:0]   retry_cnt_o;

    modport master (
        input  hmc7044_config_ok_i,
        input  lane_en_i,
        input  channel_up_i,
        output link_rst_req_o,
        output link_ok_o,
        output link_fail_o,
        output retry_cnt_o
    );

    modport slave (
        output hmc7044_config_ok_i,
        output lane_en_i,
        output channel_up_i,
        input  link_rst_req_o,
        input  link_ok_o,
        input  link_fail_o,
        input  retry_cnt_o
    );
endinterface

// File: rtl/aurora_link_supervisor.sv
// Purpose: per-lane Aurora bring-up supervisor: reset pulse, bounded wait for channel_up, retry, fail, re-reset on loss.
// Latency: channel_up rise in WAIT_UP -> link_ok_o after 2 sync + DEBOUNCE_CYC + 1 cycles; loss -> ok low after 3 cycles.
// Backpressure: none; level inputs and registered level outputs.
// Ports: clk_100m (sole clock), nrst_i (async active-low reset), lnk (aurora_link_supervisor_if.master).
// Optional feature macro LINK_AUTO_RECOVER_EN: when defined, FAIL leaves after a 16*WAIT_UP_CYC
// cool-down and re-enters RESET; when undefined, FAIL is sticky until lane_en_i or
// hmc7044_config_ok_i drops.
module aurora_link_supervisor #(
    parameter int LANES        = 4,
    parameter int WAIT_UP_CYC  = 100000,
    parameter int RST_HOLD_CYC = 128,
    parameter int MAX_RETRY    = 8,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                     clk_100m,
    input  logic                     nrst_i,
    aurora_link_supervisor_if.master lnk
);
    localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam int WAIT_W = (WAIT_UP_CYC > 1) ? $clog2(WAIT_UP_CYC) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_UP_CYC - 1);
    localparam logic [DB_W-1:0]   DB_FULL    = DB_W'(DEBOUNCE_CYC);
    localparam logic [3:0]        RETRY_MAX  = 4'(MAX_RETRY);
    localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRY - 1);
`ifdef LINK_AUTO_RECOVER_EN
    localparam int                COOL_W     = $clog2(16 * WAIT_UP_CYC);
    localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(16 * WAIT_UP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WAIT_UP,
        ST_UP,
        ST_FAIL
    } lane_state_e;

    // 2-FF synchronizers for the asynchronous status inputs
    logic             hok_s1, hok_s2;
    logic [LANES-1:0] up_s1, up_s2;

    always_ff @(posedge clk_100m or negedge nrst_i) begin
        if (!nrst_i) begin
            hok_s1 <= 1'b0;
            hok_s2 <= 1'b0;
            up_s1  <= '0;
            up_s2  <= '0;
        end else begin
            hok_s1 <= lnk.hmc7044_config_ok_i;
            hok_s2 <= hok_s1;
            up_s1  <= lnk.channel_up_i;
            up_s2  <= up_s1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_state_e       state_q, state_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [WAIT_W-1:0] wait_q, wait_d;
        logic [DB_W-1:0]   db_q;
        logic [3:0]        retry_q, retry_d;
        logic              req_q, ok_q, fail_q;
        logic              up_db, run;
`ifdef LINK_AUTO_RECOVER_EN
        logic [COOL_W-1:0] cool_q, cool_d;
`endif

        // Counter saturates at DEBOUNCE_CYC so up_db stays high while the link is stable
        assign up_db = (db_q == DB_FULL);
        assign run   = hok_s2 & lnk.lane_en_i[g];

        always_ff @(posedge clk_100m or negedge nrst_i) begin
            if (!nrst_i) begin
                db_q <= '0;
            end else if (!up_s2[g]) begin
                db_q <= '0;
            end else if (!up_db) begin
                db_q <= db_q + DB_W'(1);
            end
        end

        always_ff @(posedge clk_100m or negedge nrst_i) begin
            if (!nrst_i) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
                wait_q  <= '0;
                retry_q <= '0;
                req_q   <= 1'b1;
                ok_q    <= 1'b0;
                fail_q  <= 1'b0;
`ifdef LINK_AUTO_RECOVER_EN
                cool_q  <= '0;
`endif
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                wait_q  <= wait_d;
                retry_q <= retry_d;
                // Outputs follow the next state so they move on the same edge as state_q
                req_q   <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
                ok_q    <= (state_d == ST_UP);
                fail_q  <= (state_d == ST_FAIL);
`ifdef LINK_AUTO_RECOVER_EN
                cool_q  <= cool_d;
`endif
            end
        end

        // Timers default to zero and only advance in their own state, so every
        // entry into RESET / WAIT_UP / FAIL starts from a cleared timer.
        always_comb begin
            state_d = state_q;
            hold_d  = '0;
            wait_d  = '0;
            retry_d = retry_q;
`ifdef LINK_AUTO_RECOVER_EN
            cool_d  = '0;
`endif
            if (!run) begin
                state_d = ST_IDLE;
                retry_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_RESET;
                    ST_RESET: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_WAIT_UP;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    ST_WAIT_UP: begin
                        if (up_db) begin
                            state_d = ST_UP;
                            retry_d = '0;
                        end else if (wait_q == WAIT_LAST) begin
                            if (retry_q != RETRY_MAX) begin
                                retry_d = retry_q + 4'd1;
                            end
                            state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_RESET;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                    ST_UP: begin
                        // Loss is a single synchronized low sample, not debounced
                        if (!up_s2[g]) begin
                            state_d = ST_RESET;
                        end
                    end
                    ST_FAIL: begin
`ifdef LINK_AUTO_RECOVER_EN
                        if (cool_q == COOL_LAST) begin
                            state_d = ST_RESET;
                            retry_d = '0;
                        end else begin
                            cool_d = cool_q + COOL_W'(1);
                        end
`else
                        state_d = ST_FAIL;
`endif
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        assign lnk.link_rst_req_o[g]     = req_q;
        assign lnk.link_ok_o[g]          = ok_q;
        assign lnk.link_fail_o[g]        = fail_q;
        assign lnk.retry_cnt_o[4*g +: 4] = retry_q;
    end
endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Bench for aurora_link_supervisor with LANES=2, WAIT_UP_CYC=64, RST_HOLD_CYC=8,
// MAX_RETRY=3, DEBOUNCE_CYC=4. A sample-history model predicts every output each cycle;
// directed scenarios pin latencies and durations with literal values.
module tb_aurora_link_supervisor;
    localparam int LANES        = 2;
    localparam int WAIT_UP_CYC  = 64;
    localparam int RST_HOLD_CYC = 8;
    localparam int MAX_RETRY    = 3;
    localparam int DEBOUNCE_CYC = 4;

    localparam int PH_IDLE = 0, PH_RESET = 1, PH_WAIT = 2, PH_UP = 3, PH_FAIL = 4;

    logic clk_100m = 1'b0;
    logic nrst_i;
    always #5 clk_100m = ~clk_100m;

    aurora_link_supervisor_if #(.LANES(LANES)) lnk ();

    aurora_link_supervisor #(
        .LANES       (LANES),
        .WAIT_UP_CYC (WAIT_UP_CYC),
        .RST_HOLD_CYC(RST_HOLD_CYC),
        .MAX_RETRY   (MAX_RETRY),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk_100m(clk_100m),
        .nrst_i  (nrst_i),
        .lnk     (lnk)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- model ----------------
    // Raw input samples per edge, newest in bit 0. The FSM sees a raw value two
    // edges late; the debounce window is the four samples before that.
    bit [7:0] hok_h;
    bit [7:0] up_h [LANES];
    int       ph   [LANES];
    int       age  [LANES];
    int       nret [LANES];

    always @(posedge clk_100m or negedge nrst_i) begin : model
        int p, a, r;
        bit sy, db, run;
        if (!nrst_i) begin
            hok_h <= '0;
            for (int l = 0; l < LANES; l++) begin
                up_h[l] <= '0;
                ph[l]   <= PH_IDLE;
                age[l]  <= 0;
                nret[l] <= 0;
            end
        end else begin
            hok_h <= {hok_h[6:0], lnk.hmc7044_config_ok_i};
            for (int l = 0; l < LANES; l++) begin
                up_h[l] <= {up_h[l][6:0], lnk.channel_up_i[l]};
                p   = ph[l];
                a   = age[l];
                r   = nret[l];
                sy  = up_h[l][1];
                db  = &up_h[l][5:2];
                run = hok_h[1] && lnk.lane_en_i[l];
                if (!run) begin
                    p = PH_IDLE; a = 0; r = 0;
                end else begin
                    case (p)
                        PH_IDLE:  begin p = PH_RESET; a = 0; end
                        PH_RESET: begin
                            if (a == RST_HOLD_CYC - 1) begin p = PH_WAIT; a = 0; end
                            else a = a + 1;
                        end
                        PH_WAIT: begin
                            if (db) begin
                                p = PH_UP; r = 0;
                            end else if (a == WAIT_UP_CYC - 1) begin
                                r = r + 1;
                                a = 0;
                                p = (r == MAX_RETRY) ? PH_FAIL : PH_RESET;
                            end else a = a + 1;
                        end
                        PH_UP: begin
                            if (!sy) begin p = PH_RESET; a = 0; end
                        end
                        PH_FAIL: begin
`ifdef LINK_AUTO_RECOVER_EN
                            if (a == 16 * WAIT_UP_CYC - 1) begin p = PH_RESET; a = 0; r = 0; end
                            else a = a + 1;
`endif
                        end
                        default: p = PH_IDLE;
                    endcase
                end
                ph[l]   <= p;
                age[l]  <= a;
                nret[l] <= r;
            end
        end
    end

    always @(negedge clk_100m) begin : compare
        logic [LANES-1:0]   er, eo, ef;
        logic [4*LANES-1:0] ec;
        if (chk_en) begin
            for (int l = 0; l < LANES; l++) begin
                er[l] = (ph[l] == PH_IDLE) || (ph[l] == PH_RESET) || (ph[l] == PH_FAIL);
                eo[l] = (ph[l] == PH_UP);
                ef[l] = (ph[l] == PH_FAIL);
                ec[4*l +: 4] = 4'(nret[l]);
            end
            n_tests++;
            if ({lnk.link_rst_req_o, lnk.link_ok_o, lnk.link_fail_o, lnk.retry_cnt_o} !== {er, eo, ef, ec}) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t req=%b exp %b ok=%b exp %b fail=%b exp %b retry=%h exp %h",
                         $time, lnk.link_rst_req_o, er, lnk.link_ok_o, eo, lnk.link_fail_o, ef,
                         lnk.retry_cnt_o, ec);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({lnk.link_rst_req_o, lnk.link_ok_o, lnk.link_fail_o, lnk.retry_cnt_o});
    endfunction

    initial begin
        int cnt;
        bit saw;
        nrst_i                  = 1'b0;
        lnk.hmc7044_config_ok_i = 1'b0;
        lnk.lane_en_i           = '0;
        lnk.channel_up_i        = '0;
        repeat (3) @(negedge clk_100m);
        chk_en = 1'b1;
        // req=11 ok=00 fail=00 retry=00
        chk("reset_state", outs(), 'b11_00_00_00000000);

        // ---- nominal bring-up on lane 0 ----
        nrst_i = 1'b1;
        lnk.hmc7044_config_ok_i = 1'b1;
        repeat (4) @(negedge clk_100m);
        chk("idle_req_disabled", int'(lnk.link_rst_req_o), 3);
        lnk.lane_en_i = 2'b01;
        cnt = 0;
        do begin
            @(negedge clk_100m);
            if (lnk.link_rst_req_o[0]) cnt++;
        end while (lnk.link_rst_req_o[0] && cnt < 40);
        chk("reset_hold_len", cnt, 8);
        repeat (20) @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk_100m);
            cnt++;
        end while (!lnk.link_ok_o[0] && cnt < 30);
        chk("up_latency", cnt, 7);
        chk("lane1_idle", int'({lnk.link_rst_req_o[1], lnk.link_ok_o[1]}), 2);

        // ---- single-cycle link loss ----
        repeat (5) @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b0;
        @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b1;
        cnt = 1;
        while (lnk.link_ok_o[0] && cnt < 20) begin
            @(negedge clk_100m);
            cnt++;
        end
        chk("loss_latency", cnt, 3);
        cnt = 0;
        while (lnk.link_rst_req_o[0] && cnt < 20) begin
            cnt++;
            @(negedge clk_100m);
        end
        chk("loss_reset_len", cnt, 8);
        chk("loss_retry_zero", int'(lnk.retry_cnt_o[3:0]), 0);
        cnt = 0;
        while (!lnk.link_ok_o[0] && cnt < 10) begin
            @(negedge clk_100m);
            cnt++;
        end
        chk("loss_recovered", int'(lnk.link_ok_o[0]), 1);

        // ---- glitch rejection in WAIT_UP ----
        lnk.channel_up_i[0] = 1'b0;
        cnt = 0;
        while (!lnk.link_rst_req_o[0] && cnt < 10) begin @(negedge clk_100m); cnt++; end
        cnt = 0;
        while (lnk.link_rst_req_o[0] && cnt < 20) begin @(negedge clk_100m); cnt++; end
        chk("glitch_in_wait", int'(lnk.link_rst_req_o[0]), 0);
        repeat (2) @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b1;
        repeat (3) @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk_100m);
            if (lnk.link_ok_o[0]) saw = 1'b1;
        end
        chk("pulse3_rejected", int'(saw), 0);
        lnk.channel_up_i[0] = 1'b1;
        repeat (4) @(negedge clk_100m);
        lnk.channel_up_i[0] = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk_100m);
            if (lnk.link_ok_o[0]) saw = 1'b1;
        end
        chk("pulse4_accepted", int'(saw), 1);

        // ---- retries to FAIL ----
        cnt = 0;
        while (lnk.retry_cnt_o[3:0] != 4'd1 && cnt < 200) begin @(negedge clk_100m); cnt++; end
        chk("retry_first", int'(lnk.retry_cnt_o[3:0]), 1);
        cnt = 0;
        while (lnk.retry_cnt_o[3:0] != 4'd2 && cnt < 200) begin @(negedge clk_100m); cnt++; end
        chk("retry_interval", cnt, 72);
        cnt = 0;
        while (lnk.retry_cnt_o[3:0] != 4'd3 && cnt < 200) begin @(negedge clk_100m); cnt++; end
        chk("retry_third", cnt, 72);
        chk("fail_set", int'({lnk.link_fail_o[0], lnk.link_rst_req_o[0]}), 3);
`ifdef LINK_AUTO_RECOVER_EN
        cnt = 0;
        while (lnk.link_fail_o[0] && cnt < 1100) begin @(negedge clk_100m); cnt++; end
        chk("cooldown_len", cnt, 1024);
        chk("recover_state", int'({lnk.link_rst_req_o[0], lnk.retry_cnt_o[3:0]}), 'b1_0000);
`else
        repeat (1000) @(negedge clk_100m);
        chk("fail_sticky", int'({lnk.link_fail_o[0], lnk.link_rst_req_o[0], lnk.retry_cnt_o[3:0]}), 'b1_1_0011);
`endif

        // ---- global override ----
        lnk.lane_en_i = 2'b00;
        repeat (2) @(negedge clk_100m);
        chk("en_override", int'({lnk.link_fail_o, lnk.retry_cnt_o}), 0);
        lnk.lane_en_i = 2'b11;
        cnt = 0;
        while (lnk.retry_cnt_o != 8'h11 && cnt < 200) begin @(negedge clk_100m); cnt++; end
        chk("both_retry_one", int'(lnk.retry_cnt_o), 'h11);
        cnt = 0;
        while (lnk.link_rst_req_o != 2'b00 && cnt < 20) begin @(negedge clk_100m); cnt++; end
        repeat (10) @(negedge clk_100m);
        lnk.hmc7044_config_ok_i = 1'b0;
        repeat (2) @(negedge clk_100m);
        chk("hok_sync_delay", int'(lnk.link_rst_req_o), 0);
        @(negedge clk_100m);
        chk("hok_override", outs(), 'b11_00_00_00000000);

        // ---- async reset mid-RESET ----
        lnk.hmc7044_config_ok_i = 1'b1;
        cnt = 0;
        while (lnk.retry_cnt_o[3:0] != 4'd1 && cnt < 200) begin @(negedge clk_100m); cnt++; end
        repeat (3) @(negedge clk_100m);
        chk("pre_reset_state", int'({lnk.link_rst_req_o, lnk.retry_cnt_o}), 'b11_00010001);
        #1 nrst_i = 1'b0;
        #1 chk("async_reset", outs(), 'b11_00_00_00000000);
        @(negedge clk_100m);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
